// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, byte width and baud/clock defaults
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

    // Defaults shared by the receiver and transmitter baud generators
    localparam int unsigned UART_CLK_HZ     = 50_000_000;
    localparam int unsigned UART_BAUD       = 115_200;
    localparam int unsigned UART_OVERSAMPLE = 16;

    // Oversample tick divider, rounded to nearest
    function automatic int unsigned uart_baud_div(input int unsigned clk_hz,
                                                  input int unsigned baud);
        int unsigned tick_hz;
        tick_hz = baud * UART_OVERSAMPLE;
        return (clk_hz + tick_hz / 2) / tick_hz;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port array: synchronous write, asynchronous read
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_BYTE_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are intentionally not reset; pointers define what is valid
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte buffer with sticky overflow; optional level/irq via UART_RX_FIFO_LEVEL_EN
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_BYTE_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rx_ready,
    input  logic [WIDTH-1:0]         rx_data,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    input  logic                     m_ready,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic                     overflow,
`ifdef UART_RX_FIFO_LEVEL_EN
    input  logic [$clog2(DEPTH):0]   level_thresh,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     level_irq,
`endif
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        push;
    logic        pop;
    logic        ovf_set;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign m_valid = !empty;

    assign pop     = m_valid && m_ready;
    assign push    = rx_ready && (!full || pop);
    assign ovf_set = rx_ready && full && !pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A loss in the same cycle as a clear must stay visible
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (m_data)
    );

`ifdef UART_RX_FIFO_LEVEL_EN
    assign level = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_irq <= 1'b0;
        end else begin
            level_irq <= (level >= level_thresh) && (level != '0);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - table-driven and sequence checks for uart_rx_fifo at DEPTH=4
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_ready;
    uart_byte_t rx_data;
    logic       m_valid;
    uart_byte_t m_data;
    logic       m_ready;
    logic       flush;
    logic       ovf_clr;
    logic       overflow;
    logic       full;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level_thresh;
    logic [$clog2(DEPTH):0] level;
    logic                   level_irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(UART_BYTE_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .ovf_clr      (ovf_clr),
        .overflow     (overflow),
`ifdef UART_RX_FIFO_LEVEL_EN
        .level_thresh (level_thresh),
        .level        (level),
        .level_irq    (level_irq),
`endif
        .full         (full)
    );

    typedef struct {
        logic       rr;
        uart_byte_t rd;
        logic       mr;
        logic       fl;
        logic       oc;
        logic       e_valid;
        uart_byte_t e_data;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rr, uart_byte_t rd, logic mr, logic fl, logic oc,
                                logic ev, uart_byte_t ed, logic ef, logic eo);
        vec_t v;
        v.rr = rr; v.rd = rd; v.mr = mr; v.fl = fl; v.oc = oc;
        v.e_valid = ev; v.e_data = ed; v.e_full = ef; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, input uart_byte_t rd, input logic mr,
                         input logic fl, input logic oc);
        rx_ready = rr; rx_data = rd; m_ready = mr; flush = fl; ovf_clr = oc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        uart_byte_t q[$];
        int sent;
        int got;
        int cyc;
        logic pop_m;
        logic push_m;

        resetn = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_LEVEL_EN
        level_thresh = 3'd3;
`endif
        repeat (2) tick();
        chk("reset_valid", m_valid, 1'b0);
        chk("reset_full", full, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        resetn = 1'b1;
        tick();

        // rr, data, m_ready, flush, ovf_clr -> valid, data, full, overflow after the edge
        tbl.push_back(mk(1, 8'h41, 0, 0, 0,  1, 8'h41, 0, 0));
        tbl.push_back(mk(1, 8'h42, 0, 0, 0,  1, 8'h41, 0, 0));
        tbl.push_back(mk(1, 8'h43, 0, 0, 0,  1, 8'h41, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h42, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h43, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h10, 0, 0, 0,  1, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h11, 0, 0, 0,  1, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 0,  1, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h13, 0, 0, 0,  1, 8'h10, 1, 0));
        tbl.push_back(mk(1, 8'h99, 0, 0, 0,  1, 8'h10, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h11, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h12, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h13, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h10, 0, 0, 0,  1, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h11, 0, 0, 0,  1, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 0,  1, 8'h10, 0, 0));
        tbl.push_back(mk(1, 8'h13, 0, 0, 0,  1, 8'h10, 1, 0));
        tbl.push_back(mk(1, 8'h55, 1, 0, 0,  1, 8'h11, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h12, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h13, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h55, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 0,  1, 8'h20, 0, 0));
        tbl.push_back(mk(1, 8'h21, 0, 0, 0,  1, 8'h20, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 0,  1, 8'h20, 0, 0));
        tbl.push_back(mk(1, 8'h23, 0, 0, 0,  1, 8'h20, 1, 0));
        tbl.push_back(mk(1, 8'h24, 0, 0, 1,  1, 8'h20, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h20, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h30, 0, 0, 0,  1, 8'h30, 0, 0));
        tbl.push_back(mk(1, 8'h31, 0, 0, 0,  1, 8'h30, 0, 0));
        tbl.push_back(mk(1, 8'h77, 0, 1, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rr, tbl[i].rd, tbl[i].mr, tbl[i].fl, tbl[i].oc);
            tick();
            chk($sformatf("v%0d_valid", i), m_valid, tbl[i].e_valid);
            chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("v%0d_ovf", i), overflow, tbl[i].e_ovf);
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_data", i), m_data, tbl[i].e_data);
            end
        end

        // Interleaved push/pop of 0x00..0x09 so the pointers wrap repeatedly
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 10 && cyc < 200) begin
            chk($sformatf("wrap%0d_valid", cyc), m_valid, (q.size() > 0));
            chk($sformatf("wrap%0d_full", cyc), full, (q.size() == DEPTH));
            m_ready = ((cyc % 5) != 0);
            pop_m   = m_ready && (q.size() > 0);
            rx_ready = (sent < 10) && ((cyc % 4) != 3) && ((q.size() < DEPTH) || pop_m);
            rx_data  = uart_byte_t'(sent);
            push_m   = rx_ready;
            flush = 1'b0;
            ovf_clr = 1'b0;
            if (pop_m) begin
                chk($sformatf("wrap_order%0d", got), m_data, got);
                void'(q.pop_front());
                got++;
            end
            if (push_m) begin
                q.push_back(uart_byte_t'(sent));
                sent++;
            end
            tick();
            cyc++;
        end
        chk("wrap_done", got, 10);
        chk("wrap_ovf", overflow, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wrap_empty", m_valid, 1'b0);

        // Asynchronous reset in the middle of a cycle with data and overflow pending
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, uart_byte_t'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ovf", overflow, 1'b1);
        chk("pre_rst_full", full, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_valid", m_valid, 1'b0);
        chk("rst_async_ovf", overflow, 1'b0);
        chk("rst_async_full", full, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("post_rst_valid", m_valid, 1'b0);

`ifdef UART_RX_FIFO_LEVEL_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, uart_byte_t'(8'h70 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("level3", level, 3);
        tick();
        chk("irq_set", level_irq, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("level2", level, 2);
        tick();
        chk("irq_clr", level_irq, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
